// File: rtl/msr_pkg.sv
// msr_pkg: shared types and helpers for multimode_shift_register.
//   op_e         - 3-bit command opcodes
//   state_e      - sequencing states (IDLE, SHIFT)
//   is_shift_op  - true for the five one-bit-step operations
//   clamp_count  - limits a requested step count to the register width
package msr_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_SHL   = 3'b001,
        OP_SHR   = 3'b010,
        OP_ROL   = 3'b011,
        OP_ROR   = 3'b100,
        OP_ASR   = 3'b101,
        OP_LOAD  = 3'b110,
        OP_CLEAR = 3'b111
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic logic is_shift_op(input op_e op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
               (op == OP_ROR) || (op == OP_ASR);
    endfunction

    // More than n steps would only repeat work (or flush the register), so
    // the count saturates at the register width.
    function automatic int unsigned clamp_count(input int unsigned count,
                                                input int unsigned n);
        return (count > n) ? n : count;
    endfunction

endpackage

// File: rtl/multimode_shift_register_step.sv
// Shift datapath units for multimode_shift_register.
//   shift_step_unit   - one 1-bit step of a shift/rotate op (combinational)
//     cur_q  in  N   current register contents
//     op     in  3   opcode (non-shift ops pass cur_q through, sout=0)
//     sin    in  1   serial bit inserted by SHL/SHR
//     next_q out N   contents after one step
//     sout   out 1   bit shifted or rotated out by the step
//   shift_barrel_unit - whole multi-step shift in one cycle; present only
//     when SHIFT_BARREL_EN is defined. Same ports plus:
//     amount in  CW  number of steps (0..N)
module shift_step_unit
    import msr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] cur_q,
    input  op_e          op,
    input  logic         sin,
    output logic [N-1:0] next_q,
    output logic         sout
);

    always_comb begin
        next_q = cur_q;
        sout   = 1'b0;
        case (op)
            OP_SHL: begin
                next_q = {cur_q[N-2:0], sin};
                sout   = cur_q[N-1];
            end
            OP_SHR: begin
                next_q = {sin, cur_q[N-1:1]};
                sout   = cur_q[0];
            end
            OP_ROL: begin
                next_q = {cur_q[N-2:0], cur_q[N-1]};
                sout   = cur_q[N-1];
            end
            OP_ROR: begin
                next_q = {cur_q[0], cur_q[N-1:1]};
                sout   = cur_q[0];
            end
            OP_ASR: begin
                next_q = {cur_q[N-1], cur_q[N-1:1]};
                sout   = cur_q[0];
            end
            default: begin
                next_q = cur_q;
                sout   = 1'b0;
            end
        endcase
    end

endmodule

`ifdef SHIFT_BARREL_EN
module shift_barrel_unit
    import msr_pkg::*;
#(
    parameter int N = 8,
    localparam int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  cur_q,
    input  op_e           op,
    input  logic          sin,
    input  logic [CW-1:0] amount,
    output logic [N-1:0]  next_q,
    output logic          sout
);

    // A chain of N single-step stages; the amount selects which stage's
    // result (and the bit that stage pushed out) is taken. Building it from
    // the same step cell guarantees the result matches the iterative build
    // whenever sin is constant.
    logic [N-1:0] stage      [0:N];
    logic         stage_sout [0:N];

    assign stage[0]      = cur_q;
    assign stage_sout[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_stage
        shift_step_unit #(.N(N)) u_step (
            .cur_q  (stage[i]),
            .op     (op),
            .sin    (sin),
            .next_q (stage[i+1]),
            .sout   (stage_sout[i+1])
        );
    end

    assign next_q = stage[amount];
    assign sout   = stage_sout[amount];

endmodule
`endif

// File: rtl/multimode_shift_register.sv
// multimode_shift_register: N-bit shift register with a command handshake.
// Supports NOP, SHL, SHR, ROL, ROR, ASR (each by a clamped step count),
// LOAD and CLEAR. Multi-step shifts run one bit per clock.
// Build option: SHIFT_BARREL_EN - all shift steps complete on the accept
// edge through a barrel shifter; SHIFT is never entered and busy stays 0.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted (IDLE)
//   cmd_op     in   opcode (msr_pkg::op_e)
//   cmd_count  in   requested step count for shift ops
//   d          in   parallel load data
//   sin        in   serial input, sampled on each step edge
//   q          out  register contents
//   sout       out  bit shifted/rotated out on the most recent step
//   busy       out  multi-step shift in progress
//   done       out  one-cycle completion pulse
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a command; single-edge commands complete here
// SHIFT | stepping the latched op once per edge until remaining reaches 0
module multimode_shift_register
    import msr_pkg::*;
#(
    parameter int N = 8,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [CW-1:0] cmd_count,
    input  logic [N-1:0]  d,
    input  logic          sin,
    output logic [N-1:0]  q,
    output logic          sout,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [N-1:0]  q_d;
    logic          sout_d;
    logic          done_d;
    logic          accept;
    op_e           cmd_op_e;
    logic [CW-1:0] k;

    assign cmd_op_e  = op_e'(cmd_op);
    assign cmd_ready = (state_q == IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign k         = CW'(clamp_count(32'(cmd_count), N));

`ifdef SHIFT_BARREL_EN

    logic [N-1:0] barrel_q;
    logic         barrel_sout;

    shift_barrel_unit #(.N(N)) u_barrel (
        .cur_q  (q),
        .op     (cmd_op_e),
        .sin    (sin),
        .amount (k),
        .next_q (barrel_q),
        .sout   (barrel_sout)
    );

    assign busy = 1'b0;

    always_comb begin
        state_d = IDLE;
        q_d     = q;
        sout_d  = sout;
        done_d  = 1'b0;
        if (accept) begin
            done_d = 1'b1;
            if (is_shift_op(cmd_op_e) && (k != '0)) begin
                q_d    = barrel_q;
                sout_d = barrel_sout;
            end else if (cmd_op_e == OP_LOAD) begin
                q_d = d;
            end else if (cmd_op_e == OP_CLEAR) begin
                q_d = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            q       <= '0;
            sout    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            q       <= q_d;
            sout    <= sout_d;
            done    <= done_d;
        end
    end

`else

    op_e           op_q, op_d;
    logic [CW-1:0] remaining_q, remaining_d;
    op_e           step_op;
    logic [N-1:0]  step_q;
    logic          step_sout;

    // The first step happens on the accept edge, before op_q is latched,
    // so the step unit sees the live opcode in IDLE and the latched one
    // in SHIFT.
    assign step_op = (state_q == SHIFT) ? op_q : cmd_op_e;
    assign busy    = (state_q == SHIFT);

    shift_step_unit #(.N(N)) u_step (
        .cur_q  (q),
        .op     (step_op),
        .sin    (sin),
        .next_q (step_q),
        .sout   (step_sout)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        remaining_d = remaining_q;
        q_d         = q;
        sout_d      = sout;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift_op(cmd_op_e) && (k != '0)) begin
                        q_d    = step_q;
                        sout_d = step_sout;
                        if (k == CW'(1)) begin
                            done_d = 1'b1;
                        end else begin
                            state_d     = SHIFT;
                            op_d        = cmd_op_e;
                            remaining_d = k - CW'(1);
                        end
                    end else begin
                        done_d = 1'b1;
                        if (cmd_op_e == OP_LOAD) begin
                            q_d = d;
                        end else if (cmd_op_e == OP_CLEAR) begin
                            q_d = '0;
                        end
                    end
                end
            end
            SHIFT: begin
                q_d         = step_q;
                sout_d      = step_sout;
                remaining_d = remaining_q - CW'(1);
                if (remaining_q == CW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_NOP;
            remaining_q <= '0;
            q           <= '0;
            sout        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            remaining_q <= remaining_d;
            q           <= q_d;
            sout        <= sout_d;
            done        <= done_d;
        end
    end

`endif

endmodule

// File: tb/tb_multimode_shift_register.sv
module tb_multimode_shift_register;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    localparam logic [2:0] C_NOP   = 3'd0;
    localparam logic [2:0] C_SHL   = 3'd1;
    localparam logic [2:0] C_SHR   = 3'd2;
    localparam logic [2:0] C_ROL   = 3'd3;
    localparam logic [2:0] C_ROR   = 3'd4;
    localparam logic [2:0] C_ASR   = 3'd5;
    localparam logic [2:0] C_LOAD  = 3'd6;
    localparam logic [2:0] C_CLEAR = 3'd7;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [CW-1:0] cmd_count;
    logic [N-1:0]  d;
    logic          sin;
    logic [N-1:0]  q;
    logic          sout;
    logic          busy;
    logic          done;

    always #5 clock = ~clock;

    multimode_shift_register #(.N(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .d         (d),
        .sin       (sin),
        .q         (q),
        .sout      (sout),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [2:0]    op;
        logic [CW-1:0] count;
        logic [N-1:0]  dd;
        logic          s;
        logic [N-1:0]  exp_q;
        logic          exp_sout;
    } vec_t;

    typedef struct {
        logic [N-1:0] exp_q;
        logic         exp_sout;
        int           exp_lat;
        int           exp_busy;
        int           accept_cyc;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[18];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every done pulse retires the oldest pending command.
    always @(negedge clock) begin
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending command (t=%0t)", $time);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("q_final", 32'(q), 32'(e.exp_q));
                    check("sout_final", 32'(sout), 32'(e.exp_sout));
                    check("done_latency", 32'(cyc - e.accept_cyc), 32'(e.exp_lat));
                    check("busy_cycles", 32'(busy_cnt), 32'(e.exp_busy));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [CW-1:0] count,
                         input logic [N-1:0] dd, input logic s,
                         input logic [N-1:0] eq, input logic es, input bit track);
        int  k;
        sb_t e;
        bit  ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            #1;
            if (sb.size() == 0 && cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: got cmd_ready=%0b pending=%0d expected ready and empty", cmd_ready, sb.size());
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = count;
        d         = dd;
        sin       = s;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        if (op >= C_SHL && op <= C_ASR) k = (int'(count) > N) ? N : int'(count);
        else k = 0;
        if (track) begin
            e.exp_q      = eq;
            e.exp_sout   = es;
            e.exp_lat    = (k == 0) ? 0 : k - 1;
            e.exp_busy   = (k > 1) ? k - 1 : 0;
            e.accept_cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) return;
            @(negedge clock);
            #1;
        end
        n_checks++;
        n_fail++;
        $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{C_LOAD,  4'd0,  8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[1]  = '{C_SHL,   4'd3,  8'h00, 1'b1, 8'h2F, 1'b1};
        vecs[2]  = '{C_LOAD,  4'd0,  8'h90, 1'b0, 8'h90, 1'b1};
        vecs[3]  = '{C_ASR,   4'd2,  8'h00, 1'b0, 8'hE4, 1'b0};
        vecs[4]  = '{C_LOAD,  4'd0,  8'h3C, 1'b0, 8'h3C, 1'b0};
        vecs[5]  = '{C_ROR,   4'd12, 8'h00, 1'b0, 8'h3C, 1'b0};
        vecs[6]  = '{C_LOAD,  4'd0,  8'hAD, 1'b0, 8'hAD, 1'b0};
        vecs[7]  = '{C_SHL,   4'd1,  8'h00, 1'b0, 8'h5A, 1'b1};
        vecs[8]  = '{C_SHR,   4'd0,  8'hFF, 1'b1, 8'h5A, 1'b1};
        vecs[9]  = '{C_CLEAR, 4'd0,  8'hFF, 1'b0, 8'h00, 1'b1};
        vecs[10] = '{C_LOAD,  4'd0,  8'h0F, 1'b0, 8'h0F, 1'b1};
        vecs[11] = '{C_NOP,   4'd5,  8'hFF, 1'b0, 8'h0F, 1'b1};
        vecs[12] = '{C_ROL,   4'd8,  8'h00, 1'b0, 8'h0F, 1'b1};
        vecs[13] = '{C_SHR,   4'd4,  8'h00, 1'b1, 8'hF0, 1'b1};
        vecs[14] = '{C_LOAD,  4'd0,  8'h70, 1'b0, 8'h70, 1'b1};
        vecs[15] = '{C_ASR,   4'd15, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[16] = '{C_LOAD,  4'd0,  8'h81, 1'b0, 8'h81, 1'b0};
        vecs[17] = '{C_ROR,   4'd3,  8'h00, 1'b0, 8'h30, 1'b0};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = C_NOP;
        cmd_count = '0;
        d         = '0;
        sin       = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset with non-zero prior state (q=FE, sout=1).
        issue(C_LOAD, 4'd0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1);
        issue(C_SHL, 4'd1, 8'h00, 1'b0, 8'hFE, 1'b1, 1'b1);
        drain();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("reset_q", 32'(q), 32'h0);
        check("reset_sout", 32'(sout), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(cmd_ready), 32'h1);

        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].op, vecs[i].count, vecs[i].dd, vecs[i].s,
                  vecs[i].exp_q, vecs[i].exp_sout, 1'b1);
        end
        drain();

        // LOAD presented while busy must be ignored. q=30 -> SHL x4 sin=0 -> 00.
        issue(C_SHL, 4'd4, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = C_LOAD;
        d         = 8'hFF;
        #1;
        check("ready_low_in_shift", 32'(cmd_ready), 32'h0);
        check("busy_in_shift", 32'(busy), 32'h1);
        @(negedge clock);
        #1;
        check("ready_low_in_shift2", 32'(cmd_ready), 32'h0);
        @(negedge clock);
        cmd_valid = 1'b0;
        drain();

        // Reset in the middle of a ROL x5 on 81: after two steps q=06.
        issue(C_LOAD, 4'd0, 8'h81, 1'b0, 8'h81, 1'b1, 1'b1);
        drain();
        issue(C_ROL, 4'd5, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check("rol_two_steps", 32'(q), 32'h06);
        reset = 1'b1;
        #1;
        check("midshift_reset_q", 32'(q), 32'h0);
        check("midshift_reset_busy", 32'(busy), 32'h0);
        check("midshift_reset_ready", 32'(cmd_ready), 32'h1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        issue(C_LOAD, 4'd0, 8'h01, 1'b0, 8'h01, 1'b0, 1'b1);
        drain();
        repeat (3) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multimode_shift_register.md
Name: multimode_shift_register

Overview:
Parametrised N-bit shift register with a command handshake. Supports logical shift, rotate, arithmetic shift and multi-step shifts by a programmable count, plus load and clear. Multi-step shifts run one bit per cycle under a small FSM, with busy/done status. Intended as the general-purpose shifter for serialisers, bit-aligners and CRC/scrambler front-ends in the same design.

Parameters:
N, 8, register width (N >= 2)
CW, $clog2(N+1), width of cmd_count (localparam, derived; not overridable)

Ports:
clock      in   1   rising-edge clock
reset      in   1   asynchronous, active-high; clears all state
cmd_valid  in   1   command present
cmd_ready  out  1   block can accept a command (high in IDLE)
cmd_op     in   3   operation code, see Behaviour
cmd_count  in   CW  number of 1-bit steps for shift/rotate ops
d          in   N   parallel load data, sampled on accept edge
sin        in   1   serial input bit, sampled on every step edge
q          out  N   register contents
sout       out  1   bit shifted/rotated out on the most recent step
busy       out  1   multi-step operation in progress (state == SHIFT)
done       out  1   one-cycle pulse, the cycle after a command's final update

Behaviour:
- Reset (async, active-high): q=0, sout=0, done=0, busy=0, state=IDLE, cmd_ready=1 once reset deasserts.
- Opcodes: 000 NOP; 001 SHL (sin -> LSB, MSB -> sout); 010 SHR (sin -> MSB, LSB -> sout); 011 ROL; 100 ROR; 101 ASR (MSB replicated, LSB -> sout); 110 LOAD (q <= d); 111 CLEAR (q <= 0). Codes 001-101 are "shift ops". ROL/ROR drive the rotated bit to sout.
- Accept = cmd_valid & cmd_ready on a rising edge. cmd_ready = (state == IDLE). Commands presented while busy are ignored, not queued.
- Count is clamped: k = min(cmd_count, N).
- NOP, LOAD, CLEAR, or a shift op with k = 0: the update (if any) occurs on the accept edge; state stays IDLE; done=1 in the next cycle. sout is unchanged by these.
- Shift op with k >= 1: the first step occurs on the accept edge. If k == 1, stay IDLE. Otherwise go to SHIFT with remaining = k-1.
- In SHIFT, one step occurs per edge and remaining decrements. The edge performing the last step returns the FSM to IDLE.
- Timing: the final q is visible after k edges counted from and including the accept edge. done pulses in the cycle after that edge. done coincides with cmd_ready=1, so back-to-back commands are allowed in the done cycle.
- op and k are latched at accept. d and cmd_* are don't-care during SHIFT. sin is live and sampled on each step edge.
- Reset mid-SHIFT: immediate return to IDLE, q=0, no done pulse.
- done never asserts for two consecutive cycles from a single command.

Optional Feature:
SHIFT_BARREL_EN:
- Defined: shift ops complete entirely on the accept edge via a barrel shifter. Inserted bits are all sin (SHL/SHR), MSB copies (ASR) or wrapped bits (ROL/ROR). sout = last bit shifted out. The SHIFT state is never entered, busy is tied 0, and done pulses the cycle after accept.
- Undefined: iterative one-bit-per-cycle operation as above.
- Final q and sout are identical in both builds whenever sin is held constant during the operation.

Decomposition:
- Package msr_pkg holds:
  - op_e enum (the 8 opcodes)
  - state_e enum (IDLE, SHIFT)
  - function is_shift_op
  - function clamp_count
- One combinational sub-module, shift_step_unit: takes q, op, sin and returns next q and sout for a single step. Under SHIFT_BARREL_EN it is replaced by shift_barrel_unit, which adds an amount input.

Test Plan:
1. Hold reset with prior q=8'hFF -> q=8'h00, sout=0, busy=0, done=0; cmd_ready=1 after release.
2. LOAD d=8'hA5 -> q=8'hA5 after accept edge; done=1 for exactly the next cycle; busy never 1.
3. From q=8'hA5, SHL k=3, sin=1 -> q sequence 4B, 97, 2F on successive edges; sout=1; busy=1 for 2 cycles; done the cycle after the 3rd edge.
4. From q=8'h90, ASR k=2 -> C8 then E4, sout=0. Then ROR cmd_count=12 on 8'h3C -> clamped to 8 steps, final q=8'h3C, done after 8th edge.
5. Shift op with cmd_count=0 on q=8'h5A -> q unchanged, sout unchanged, done next cycle. A LOAD presented during SHIFT is ignored (q unaffected, cmd_ready=0).
6. ROL k=5 on 8'h81, assert reset after the 2nd step edge -> q=0 immediately, state IDLE, no done pulse. A subsequent LOAD 8'h01 is accepted normally.
